// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a ROM and a RAM.
// One transaction in flight at a time: accept, access, respond.
// Address bit AW picks the RAM (1) or the ROM (0); a write aimed at the
// ROM completes with an error flag and never reaches either memory.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 64,
    localparam int AW = $clog2(ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_valid,
    output logic                  m0_ready,
    input  logic                  m0_we,
    input  logic [AW:0]           m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_err,

    input  logic                  m1_valid,
    output logic                  m1_ready,
    input  logic                  m1_we,
    input  logic [AW:0]           m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_err,

    output logic                  ram_we,
    output logic [AW-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,

    output logic [AW-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rdata,

    output logic                  sel_ram
);

    // state  | meaning
    // IDLE   | waiting for a request; grant and latch happen here
    // ACCESS | memory addressed with the latched index (RAM write strobes here)
    // RESP   | one-cycle response to the granted requester
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_ptr;      // 0: m0 has priority, 1: m1 has priority
    logic                  r_gnt;      // requester owning the current transaction
    logic                  r_we;
    logic                  r_sel;      // latched address bit AW
    logic [AW-1:0]         r_idx;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_accept;
    logic                  w_resp;
    logic                  w_rom_wr;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [AW:0]           w_addr_mux;
    logic                  w_we_mux;
    logic [DATA_WIDTH-1:0] w_wdata_mux;

    // Next-state and round-robin grant decode
    always_comb begin
        w_next_state = r_state;
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        case (r_state)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    w_gnt0       = m0_valid && (!r_ptr || !m1_valid);
                    w_gnt1       = !w_gnt0;
                    w_next_state = ACCESS;
                end
            end
            ACCESS:  w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    assign w_accept    = w_gnt0 | w_gnt1;
    assign w_addr_mux  = w_gnt1 ? m1_addr  : m0_addr;
    assign w_we_mux    = w_gnt1 ? m1_we    : m0_we;
    assign w_wdata_mux = w_gnt1 ? m1_wdata : m0_wdata;

    // State register and priority pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_ptr <= w_gnt0;
            end
        end
    end

    // Capture the granted request; the address and select then hold until the next accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt   <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_gnt   <= w_gnt1;
            r_we    <= w_we_mux;
            r_sel   <= w_addr_mux[AW];
            r_idx   <= w_addr_mux[AW-1:0];
            r_wdata <= w_wdata_mux;
        end
    end

    // Ready is gated by reset so the combinational path stays quiet while rst is high
    assign m0_ready  = w_gnt0 & ~rst;
    assign m1_ready  = w_gnt1 & ~rst;

    assign ram_addr  = r_idx;
    assign rom_addr  = r_idx;
    assign sel_ram   = r_sel;
    assign ram_wdata = r_wdata;
    assign ram_we    = (r_state == ACCESS) && r_we && r_sel;

    // Writes (legal or not) return zero data; reads take the memory picked by the latched select
    assign w_resp    = (r_state == RESP);
    assign w_rom_wr  = r_we & ~r_sel;
    assign w_rd_data = r_we ? '0 : (r_sel ? ram_rdata : rom_rdata);

    assign m0_rvalid = w_resp & ~r_gnt;
    assign m1_rvalid = w_resp &  r_gnt;
    assign m0_rdata  = m0_rvalid ? w_rd_data : '0;
    assign m1_rdata  = m1_rvalid ? w_rd_data : '0;
    assign m0_err    = m0_rvalid & w_rom_wr;
    assign m1_err    = m1_rvalid & w_rom_wr;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
- REQ-001: Parameter DATA_WIDTH, default 32, word width of all data paths.
- REQ-002: Parameter ADDR_WIDTH, default 64, depth in words of each memory; AW = clog2(ADDR_WIDTH) = 6.
- REQ-003: clk  input  1  single clock; all state changes on its rising edge.
- REQ-004: rst  input  1  reset, asynchronous, active-high.
- REQ-005: mN_valid  input  1  request valid from requester N (N = 0, 1).
- REQ-006: mN_ready  output  1  request accepted from requester N this cycle.
- REQ-007: mN_we  input  1  1 = write, 0 = read.
- REQ-008: mN_addr  input  AW+1  bit AW selects RAM (1) or ROM (0); bits AW-1:0 are the word index.
- REQ-009: mN_wdata  input  DATA_WIDTH  write data.
- REQ-010: mN_rvalid  output  1  one-cycle response strobe to requester N.
- REQ-011: mN_rdata  output  DATA_WIDTH  read data, valid with mN_rvalid.
- REQ-012: mN_err  output  1  error flag, valid with mN_rvalid.
- REQ-013: ram_we  output  1; ram_addr  output  AW; ram_wdata  output  DATA_WIDTH; ram_rdata  input  DATA_WIDTH. RAM port, synchronous read, one-cycle latency.
- REQ-014: rom_addr  output  AW; rom_rdata  input  DATA_WIDTH. ROM port, synchronous read, one-cycle latency.
- REQ-015: sel_ram  output  1  drives the ROM/RAM output mux; 1 selects RAM.

Function
- REQ-016: The FSM SHALL have states IDLE, ACCESS and RESP; at most one transaction is in flight.
- REQ-017: IDLE: when at least one mN_valid is 1, the arbiter grants exactly one requester, asserts its mN_ready for that cycle, latches we/addr/wdata and the grant ID, and moves to ACCESS; otherwise it stays in IDLE.
- REQ-018: Arbitration SHALL be round-robin. The priority pointer starts at m0. After a grant to N, priority passes to the other requester.
- REQ-019: mN_ready SHALL be 1 only in IDLE, and only for the granted requester. It is combinational from mN_valid and the pointer.
- REQ-020: ACCESS: the arbiter drives ram_addr/rom_addr with the latched index and sel_ram with the latched bit AW, then moves to RESP.
- REQ-021: ram_we SHALL be 1 for exactly the ACCESS cycle of a RAM write, with ram_wdata = latched wdata; ram_we is 0 at all other times.
- REQ-022: RESP: the granted requester receives mN_rvalid = 1 for one cycle. For a read, mN_rdata = rom_rdata or ram_rdata according to the latched select. The FSM then returns to IDLE.
- REQ-023: A write to ROM (we = 1, bit AW = 0) SHALL NOT touch either memory and completes normally with mN_err = 1 and mN_rdata = 0.
- REQ-024: A RAM write response SHALL have mN_err = 0 and mN_rdata = 0.
- REQ-025: The non-granted requester's rvalid, rdata and err SHALL remain 0.
- REQ-026: Latency SHALL be accept cycle T, ACCESS at T+1, response at T+2. Next accept is no earlier than T+3, giving peak throughput of one transaction per 3 cycles.
- REQ-027: A requester holding mN_valid with ready = 0 is not dropped; it is granted by the next IDLE cycle in which it holds priority or is the only requester.
- REQ-028: ram_addr/rom_addr SHALL hold their last value outside ACCESS. sel_ram SHALL hold from ACCESS through RESP.

Reset
- REQ-029: While rst = 1: state = IDLE, pointer = m0, and every output (ready, rvalid, rdata, err, ram_we, addresses, wdata, sel_ram) = 0, asynchronously.
- REQ-030: Reset asserted during ACCESS or RESP SHALL abort the transaction. ram_we drops immediately, no response strobe is issued after reset, and the aborted request is not replayed.

Verification
- REQ-031: Reset, then m0 reads RAM addr 7'h45 with the RAM preloaded with word 5 = 32'hDEADBEEF -> m0_ready at T, ram_addr = 5 and sel_ram = 1 at T+1, m0_rvalid = 1 with m0_rdata = 32'hDEADBEEF and m0_err = 0 at T+2.
- REQ-032: m1 writes 32'h12345678 to 7'h7F, then reads it back -> ram_we = 1 only in the ACCESS cycle with ram_addr = 63, and the read returns 32'h12345678.
- REQ-033: m0 writes to ROM addr 7'h03 -> ram_we stays 0, and m0_rvalid = 1 with m0_err = 1 and m0_rdata = 0.
- REQ-034: m0 and m1 both hold valid continuously for 6 transactions -> grant order m0, m1, m0, m1, m0, m1, spaced every 3 cycles, with no lost request.
- REQ-035: rst pulsed during the ACCESS cycle of a RAM write -> ram_we = 0 immediately, no rvalid follows, and the pointer is back at m0.
